fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core. It owns the program counter and issues one word request at a time to instruction memory. It absorbs taken branch/jump redirects from execute and stalls from the hazard logic, and drives the IF/ID register whose opcode field feeds the main decoder's `op_i`. At most one memory request is outstanding, and a response belonging to a squashed PC is never delivered downstream.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/if_id_reg.sv | 64 ++++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush, load, stall and bubble
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int             W        = 32,
    parameter logic [W-1:0]   RESET_PC = W'(DEFAULT_RESET_PC)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         load_i,
    input  logic         stall_i,
    input  logic [W-1:0] ld_instr_i,
    input  logic [W-1:0] ld_pc_i,
    output logic         valid_o,
    output logic [W-1:0] instr_o,
    output logic [W-1:0] pc_o,
    output logic [W-1:0] pc_plus4_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] instr_q, instr_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] pc4_q, pc4_d;

    // Flush beats everything; a load fills the slot even under stall when the slot is empty
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = ld_instr_i;
            pc_d    = ld_pc_i;
            pc4_d   = ld_pc_i + W'(4);
        end else if (!stall_i) begin
            valid_d = 1'b0;
        end
    end

    // Register state with asynchronous reset to a NOP at the reset PC
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            instr_q <= W'(NOP_INSTR);
            pc_q    <= RESET_PC;
            pc4_q   <= RESET_PC + W'(4);
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner issuing one outstanding instruction fetch at a time
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [6:0]            op_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o
);

    fetch_state_t          st_q, st_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [DATA_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] ld_instr, ld_pc;
    logic                  ld, req;

    assign target = redirect_pc_i & ~DATA_WIDTH'(3);

    // Next-state logic: a redirect always wins, and any in-flight word is either consumed, parked or dropped
    always_comb begin
        st_d         = st_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        ld           = 1'b0;
        ld_instr     = imem_rdata_i;
        ld_pc        = pc_q;
        req          = 1'b0;
        case (st_q)
            ST_REQ: begin
                if (redirect_i) begin
                    pc_d = target;
                end else begin
                    req  = 1'b1;
                    st_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (redirect_i) begin
                        pc_d = target;
                        st_d = ST_REQ;
                    end else if (!stall_i || !valid_o) begin
                        ld   = 1'b1;
                        pc_d = pc_q + DATA_WIDTH'(4);
                        st_d = ST_REQ;
                    end else begin
                        hold_instr_d = imem_rdata_i;
                        hold_pc_d    = pc_q;
                        pc_d         = pc_q + DATA_WIDTH'(4);
                        st_d         = ST_HOLD;
                    end
                end else if (redirect_i) begin
                    pc_d = target;
                    st_d = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    pc_d = target;
                    st_d = ST_REQ;
                end else if (!stall_i) begin
                    ld       = 1'b1;
                    ld_instr = hold_instr_q;
                    ld_pc    = hold_pc_q;
                    st_d     = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (redirect_i) begin
                    pc_d = target;
                end
                if (imem_rvalid_i) begin
                    st_d = ST_REQ;
                end
            end
            default: st_d = ST_REQ;
        endcase
    end

    // FSM, PC and hold buffer registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q         <= ST_REQ;
            pc_q         <= DATA_WIDTH'(RESET_PC);
            hold_instr_q <= DATA_WIDTH'(NOP_INSTR);
            hold_pc_q    <= DATA_WIDTH'(RESET_PC);
        end else begin
            st_q         <= st_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign imem_req_o  = req && !rst_i;
    assign imem_addr_o = pc_q;

    if_id_reg #(
        .W        (DATA_WIDTH),
        .RESET_PC (DATA_WIDTH'(RESET_PC))
    ) u_if_id (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (redirect_i),
        .load_i     (ld),
        .stall_i    (stall_i),
        .ld_instr_i (ld_instr),
        .ld_pc_i    (ld_pc),
        .valid_o    (valid_o),
        .instr_o    (instr_o),
        .pc_o       (pc_o),
        .pc_plus4_o (pc_plus4_o)
    );

    assign op_o = instr_o[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized word-lifecycle checking of fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [6:0]  op_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;

    fetch_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (redir_pc),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .op_o          (op_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Reference model: words in flight, parked words, next fetch address, IF/ID contents
    int          cyc = 0;
    bit          pending = 0;
    int          resp_cyc = 0;
    logic [31:0] p_addr = 32'h0;
    bit          p_stale = 0;
    bit          held = 0;
    logic [31:0] h_addr = 32'h0;
    logic [31:0] fetch_pc = 32'h0;
    bit          m_valid = 0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_pc = 32'h0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          delivered = 0;

    task automatic model_reset();
        pending  = 0;
        held     = 0;
        p_stale  = 0;
        fetch_pc = 32'h0;
        m_valid  = 0;
        m_instr  = NOP;
        m_pc     = 32'h0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   32'(imem_req_o), 32'd0);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_instr"}, instr_o, NOP);
        chk({tag, "_op"},    32'(op_o), 32'h13);
        chk({tag, "_pc"},    pc_o, 32'h0);
        chk({tag, "_pc4"},   pc_plus4_o, 32'h4);
    endtask

    // One clock of stimulus; called at posedge+1
    task automatic step(input bit s, input bit r, input logic [31:0] tgt, input bit ghost);
        bit          rv;
        bit          exp_req;
        bit          ld;
        logic [31:0] ld_addr;
        rv       = pending && (cyc == resp_cyc);
        stall    = s;
        redir    = r;
        redir_pc = tgt;
        rvalid   = rv | ghost;
        rdata    = rv ? mem_word(p_addr) : 32'hDEAD_BEEF;
        #1;
        exp_req = !pending && !held && !r;
        chk("imem_req", 32'(imem_req_o), 32'(exp_req));
        if (exp_req && imem_req_o) chk("imem_addr", imem_addr_o, fetch_pc);
        ld      = 0;
        ld_addr = 32'h0;
        if (r) begin
            if (pending) begin
                if (rv) pending = 0;
                else p_stale = 1;
            end
            held     = 0;
            fetch_pc = tgt & ~32'd3;
        end else if (rv) begin
            pending = 0;
            if (!p_stale) begin
                if (!s || !m_valid) begin
                    ld      = 1;
                    ld_addr = p_addr;
                end else begin
                    held   = 1;
                    h_addr = p_addr;
                end
            end
        end else if (held && !s) begin
            ld      = 1;
            ld_addr = h_addr;
            held    = 0;
        end
        if (exp_req) begin
            pending  = 1;
            p_stale  = 0;
            p_addr   = fetch_pc;
            resp_cyc = cyc + int'($urandom_range(lat_max, lat_min));
            fetch_pc = fetch_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (r) m_valid = 0;
        else if (ld) begin
            m_valid = 1;
            m_instr = mem_word(ld_addr);
            m_pc    = ld_addr;
            delivered++;
        end else if (!(s && m_valid)) m_valid = 0;
        chk("valid_o", 32'(valid_o), 32'(m_valid));
        if (m_valid) begin
            chk("instr_o", instr_o, m_instr);
            chk("pc_o", pc_o, m_pc);
            chk("pc_plus4_o", pc_plus4_o, m_pc + 32'd4);
            chk("op_o", 32'(op_o), 32'(m_instr[6:0]));
        end
    endtask

    initial begin
        logic [31:0] tgt;
        int          guard;
        bit          s;
        bit          r;

        // Reset state
        @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // 1-cycle memory, free running: requests 0x0, 0x4, 0x8 on alternating cycles
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 12; i++) step(0, 0, 32'h0, 0);

        // Stall for 3 cycles across a response
        step(1, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0);

        // Redirect to 0x100 in WAIT with 3-cycle memory
        lat_min = 3;
        lat_max = 3;
        guard = 0;
        while (!pending && guard < 10) begin
            step(0, 0, 32'h0, 0);
            guard++;
        end
        step(0, 0, 32'h0, 0);
        step(0, 1, 32'h0000_0102, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 32'h0, 0);

        // Redirect together with stall while IF/ID is valid
        lat_min = 1;
        lat_max = 1;
        guard = 0;
        while (valid_o !== 1'b1 && guard < 20) begin
            step(0, 0, 32'h0, 0);
            guard++;
        end
        chk("valid_before_flush", 32'(valid_o), 32'd1);
        step(1, 1, 32'h0000_0200, 0);
        chk("flush_over_stall", 32'(valid_o), 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 0);

        // PC wrap from 0xFFFF_FFFC to 0
        step(0, 1, 32'hFFFF_FFFD, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 32'h0, 0);

        // Randomized stall/redirect/latency mix
        for (int blk = 0; blk < 6; blk++) begin
            lat_min = 1;
            lat_max = int'($urandom_range(4, 1));
            for (int i = 0; i < 500; i++) begin
                s = ($urandom_range(99, 0) < 30);
                r = ($urandom_range(99, 0) < 7);
                case ($urandom_range(3, 0))
                    0: tgt = 32'h0000_0100;
                    1: tgt = 32'hFFFF_FFF8 | 32'($urandom_range(7, 0));
                    default: tgt = $urandom;
                endcase
                step(s, r, tgt, 0);
            end
        end
        chk("enough_deliveries", 32'(delivered > 200), 32'd1);

        // Reset pulsed mid-WAIT, then a late response arrives
        lat_min = 3;
        lat_max = 3;
        step(0, 1, 32'h0000_0400, 0);
        guard = 0;
        while (!pending && guard < 10) begin
            step(0, 0, 32'h0, 0);
            guard++;
        end
        step(0, 0, 32'h0, 0);
        stall  = 1'b0;
        redir  = 1'b0;
        rvalid = 1'b0;
        rst    = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk);
        #1;
        chk_reset_vals("midrst_hold");
        rst = 1'b0;
        model_reset();
        step(0, 0, 32'h0, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 32'h0, 0);
        chk("restart_pc", pc_o, 32'h0000_0008);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
